fp_cvt_scheduler: RTL
=====================

# fp_cvt_scheduler

Shared, multi-cycle IEEE-754 single-precision to 8-bit unsigned integer conversion unit. NREQ requesters share one iterative converter. A round-robin arbiter decides which requester is served next. Results return on a single tagged valid/ready output channel. Conversion truncates toward zero, saturates at 255 and flags out-of-range inputs.

## Interface
- NREQ, 2: number of requesters (2..8).
- IDW, $clog2(NREQ): requester-id width.
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  per-requester request valid.
- req_fp  in  32*NREQ  flattened operands; requester i is bits [32*i+31:32*i].
- req_ready  out  NREQ  one-hot grant/accept; at most one bit high per cycle.
- res_valid  out  1  result valid.
- res_ready  in  1  result consumer ready.
- res_id  out  IDW  requester index owning the result.
- res_int  out  8  converted value.
- res_flags  out  3  {nan, neg, ovf}.

## Operation
- Classification of the latched operand (s = sign, e = exp field, m = mantissa), highest priority first:
  - e==255, m!=0: result 0, nan=1.
  - e==255, m==0, s=0: result 255, ovf=1.
  - e==255, m==0, s=1: result 0, neg=1.
  - e==0 (zero or denormal): result 0, no flags. -0.0 is not flagged.
  - s=1: result 0, neg=1.
  - k=e-127 <0: result 0, no flags.
  - k>7: result 255, ovf=1.
  - otherwise: normal path, k in 0..7.
- Normal path: acc starts at 0. Shift in the bits of {1,m} MSB-first, one bit per cycle, for k+1 cycles. The result is acc, which equals floor(value). This path never sets a flag.
- FSM states:
  - IDLE: if any req_valid, assert req_ready for the arbiter winner. On that handshake edge, latch fp and id; go to CLASS.
  - CLASS: evaluate the classification. Normal goes to SHIFT with count=k. Special goes directly to DONE with result and flags loaded.
  - SHIFT: shift one bit per cycle. When count reaches 0, go to DONE.
  - DONE: hold res_valid=1 with stable res_id, res_int and res_flags. On res_valid&res_ready, go to IDLE.
- req_ready is 0 in every state other than IDLE, so only one conversion is in flight.
- Round-robin arbitration:
  - Priority starts at last_grant+1, modulo NREQ.
  - last_grant updates only on an accepted handshake.
  - Reset value of last_grant is NREQ-1, so requester 0 wins first.
- req_ready depends combinationally on req_valid and state. It is never asserted for a requester whose valid is low.

## Timing
- Reset values:
  - state=IDLE.
  - req_ready=0 while rst_n low.
  - res_valid=0, res_id=0, res_int=0, res_flags=0.
  - last_grant=NREQ-1.
- Latency is counted from the accept edge to the first res_valid cycle:
  - Special cases: 2 cycles.
  - Normal path: k+3 cycles, which ranges 3..10.
- res_ready may stay high continuously. The earliest next accept is the cycle after the DONE handshake, because that cycle is IDLE.
- Back-pressure: res_valid stays asserted and outputs stay frozen while res_ready=0.
- Simultaneous requests: only the winner is accepted. Losers keep valid high and their operands stable, and are served in round-robin order.
- Reset mid-operation aborts the conversion and discards the latched operand. No res_valid pulse occurs after reset is released until a new accept.

## Structure
- Package fp_cvt_pkg holds:
  - the state enum {IDLE, CLASS, SHIFT, DONE};
  - FP_BIAS=127 and EXP_SPECIAL=255;
  - flag bit indices FLG_OVF=0, FLG_NEG=1, FLG_NAN=2.
- Sub-module rr_arbiter(NREQ) is instantiated once. It takes req, advance and last_grant, and returns a one-hot grant. Its grant output drives req_ready while the FSM is in IDLE.

## Test plan
- Single requester, 0x3F800000 (1.0) -> res_int=1, flags=0, res_valid 3 cycles after accept. 0x42DE8000 (111.25) -> 111 after 9 cycles.
- 0x437F0000 (255.0) -> 255, flags=0. 0x43800000 (256.0) -> 255, ovf=1, latency 2. 0x7F800000 -> 255, ovf=1. 0x7FC00000 -> 0, nan=1.
- 0x00000000 -> 0, no flags. 0x80000000 -> 0, no flags. 0xBFC00000 (-1.5) -> 0, neg=1. 0x3F7FFFFF (0.99999) -> 0, no flags. 0x4033D70A (2.99) -> 2.
- Both requesters valid continuously with different operands -> grants alternate 0,1,0,1. res_id matches the grant, and each requester's result matches its own operand.
- res_ready held low 5 cycles in DONE -> outputs stable, no new req_ready. The accept occurs the cycle after the handshake.
- rst_n pulsed low during SHIFT of 0x42CC3B23 (102.1155) -> all outputs return to reset values immediately, no stale result afterward. Re-issued request -> 102.

Source files
------------

// File: rtl/fp_cvt_pkg.sv
// Shared types, constants and operand classification for the float-to-uint8 converter.
package fp_cvt_pkg;

   typedef enum logic [1:0] {IDLE, CLASS, SHIFT, DONE} state_t;

   localparam logic [7:0] FP_BIAS     = 8'd127;
   localparam logic [7:0] EXP_SPECIAL = 8'd255;

   localparam int FLG_OVF = 0;
   localparam int FLG_NEG = 1;
   localparam int FLG_NAN = 2;

   typedef struct packed {
      logic [7:0] value;
      logic [2:0] flags;
      logic       normal;
      logic [2:0] k;
   } class_t;

   // Highest-priority rule wins; only finite positives with exponent 0..7 take the shift path.
   function automatic class_t classify(input logic [31:0] fp);
      class_t     c;
      logic       s;
      logic [7:0] e;
      logic [22:0] m;
      s = fp[31];
      e = fp[30:23];
      m = fp[22:0];
      c = '0;
      if (e == EXP_SPECIAL) begin
         if (m != 23'd0) begin
            c.flags[FLG_NAN] = 1'b1;
         end else if (!s) begin
            c.value          = 8'd255;
            c.flags[FLG_OVF] = 1'b1;
         end else begin
            c.flags[FLG_NEG] = 1'b1;
         end
      end else if (s && (e != 8'd0)) begin
         c.flags[FLG_NEG] = 1'b1;
      end else if (e > (FP_BIAS + 8'd7)) begin
         c.value          = 8'd255;
         c.flags[FLG_OVF] = 1'b1;
      end else if (e >= FP_BIAS) begin
         c.normal = 1'b1;
         c.k      = 3'(e - FP_BIAS);
      end
      return c;
   endfunction

endpackage

// File: rtl/fp_cvt_scheduler_rr_arbiter.sv
// Round-robin arbiter: searches from the requester after the last accepted one.
module rr_arbiter #(
   parameter int NREQ = 2,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [NREQ-1:0] req,
   input  logic            advance,
   output logic [NREQ-1:0] grant,
   output logic [IDW-1:0]  grant_id,
   output logic [IDW-1:0]  last_grant
);

   always_comb begin
      int         tmp;
      logic [IDW-1:0] idx;
      logic       found;
      grant    = '0;
      grant_id = '0;
      found    = 1'b0;
      tmp      = 0;
      idx      = '0;
      for (int off = 1; off <= NREQ; off++) begin
         tmp = int'(last_grant) + off;
         if (tmp >= NREQ) begin
            tmp = tmp - NREQ;
         end
         idx = IDW'(tmp);
         if (!found && req[idx]) begin
            found      = 1'b1;
            grant[idx] = 1'b1;
            grant_id   = idx;
         end
      end
   end

   // Reset to the highest index so requester 0 is first in line.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant <= IDW'(NREQ - 1);
      end else if (advance) begin
         last_grant <= grant_id;
      end
   end

endmodule

// File: rtl/fp_cvt_scheduler.sv
// Shared iterative float32 -> uint8 converter serving NREQ requesters round-robin.
module fp_cvt_scheduler
   import fp_cvt_pkg::*;
#(
   parameter int NREQ = 2,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NREQ-1:0]    req_valid,
   input  logic [32*NREQ-1:0] req_fp,
   output logic [NREQ-1:0]    req_ready,
   output logic               res_valid,
   input  logic               res_ready,
   output logic [IDW-1:0]     res_id,
   output logic [7:0]         res_int,
   output logic [2:0]         res_flags
);

   state_t          state;
   state_t          state_nxt;
   logic [NREQ-1:0] grant;
   logic [IDW-1:0]  grant_id;
   logic [IDW-1:0]  last_grant;
   logic            accept;
   logic [31:0]     op_fp;
   logic [IDW-1:0]  op_id;
   logic [23:0]     mant_sr;
   logic [7:0]      acc;
   logic [7:0]      acc_shifted;
   logic [2:0]      count;
   class_t          cls;

   rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
      .clk        (clk),
      .rst_n      (rst_n),
      .req        (req_valid),
      .advance    (accept),
      .grant      (grant),
      .grant_id   (grant_id),
      .last_grant (last_grant)
   );

   assign accept      = (state == IDLE) && (|grant);
   assign req_ready   = ((state == IDLE) && rst_n) ? grant : '0;
   assign cls         = classify(op_fp);
   assign acc_shifted = {acc[6:0], mant_sr[23]};
   assign res_valid   = (state == DONE);
   assign res_id      = op_id;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = CLASS;
         CLASS:   state_nxt = cls.normal ? SHIFT : DONE;
         SHIFT:   if (count == 3'd0) state_nxt = DONE;
         DONE:    if (res_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Normal path shifts {1,m} MSB-first into acc for k+1 cycles, leaving floor(value).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_fp     <= '0;
         op_id     <= '0;
         mant_sr   <= '0;
         acc       <= '0;
         count     <= '0;
         res_int   <= '0;
         res_flags <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  op_fp <= req_fp[int'(grant_id)*32 +: 32];
                  op_id <= grant_id;
               end
            end
            CLASS: begin
               if (cls.normal) begin
                  acc     <= '0;
                  mant_sr <= {1'b1, op_fp[22:0]};
                  count   <= cls.k;
               end else begin
                  res_int   <= cls.value;
                  res_flags <= cls.flags;
               end
            end
            SHIFT: begin
               acc     <= acc_shifted;
               mant_sr <= {mant_sr[22:0], 1'b0};
               count   <= count - 3'd1;
               if (count == 3'd0) begin
                  res_int   <= acc_shifted;
                  res_flags <= '0;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule
